// File: rtl/param_wb_loader.sv
// Streams a block of parameter words from the parameter SRAM onto the
// (param, valid) pair feeding param_wb, one word per cycle, honouring read stalls.
module param_wb_loader #(
    parameter int BIT_DATA = 16,
    parameter int ADDR_W   = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_Start,
    input  logic [ADDR_W-1:0]   i_Base_Addr,
    input  logic [ADDR_W:0]     i_Length,
    input  logic                i_Stall,
    output logic                o_Mem_Rd_En,
    output logic [ADDR_W-1:0]   o_Mem_Addr,
    input  logic [BIT_DATA-1:0] i_Mem_Rd_Data,
    output logic [BIT_DATA-1:0] o_Param_WB,
    output logic                o_Valid_WB_Param,
    output logic                o_Busy,
    output logic                o_Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic                rd_en_d1_q, rd_en_d1_d;
    logic [BIT_DATA-1:0] param_q, param_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                rd_en;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        rd_en      = (state_q == READ) && !i_Stall;
        rd_en_d1_d = rd_en;
        // Bubbles are presented as zero so param_wb sees clean idle data.
        param_d    = rd_en_d1_q ? i_Mem_Rd_Data : '0;
        valid_d    = rd_en_d1_q;

        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    if (i_Length != '0) begin
                        addr_d   = i_Base_Addr;
                        remain_d = i_Length;
                        state_d  = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_en) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last read's data is being registered on this edge.
                if (rd_en_d1_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            rd_en_d1_q <= 1'b0;
            param_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_en_d1_q <= rd_en_d1_d;
            param_q    <= param_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign o_Mem_Rd_En      = rd_en;
    assign o_Mem_Addr       = addr_q;
    assign o_Param_WB       = param_q;
    assign o_Valid_WB_Param = valid_q;
    assign o_Busy           = (state_q == READ) || (state_q == DRAIN);
    assign o_Done           = done_q;

endmodule
